uart_rx_fifo_gen: RTL and testbench

Parametrised next-generation UART receiver with an integrated receive FIFO.
- Generalises the current receiver: configurable oversampling ratio, majority-vote bit sampling, false-start rejection, 1 or 2 stop bits, stick parity, and per-character error status stored alongside the data.
- Sits between the board RX pin (via the baud generator tick) and the bus-side UART register file, which pops characters.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_sync_fifo.sv | 40 ++++
 rtl/uart_rx_fifo_gen.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state, control-field and status definitions for the UART receiver
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} rxState_t;
    localparam int CTL_PAR_EN = 2;
    localparam int CTL_ODD    = 3;
    localparam int CTL_STICK  = 4;
    localparam int CTL_STOP2  = 5;
    localparam int CTL_ENABLE = 6;
    localparam int ST_BREAK   = 2;
    localparam int ST_PARITY  = 1;
    localparam int ST_FRAME   = 0;
    function automatic logic [3:0] dataBitCount(input logic [1:0] code);
        return 4'd5 + 4'(code);
    endfunction
endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: synchronous first-word-fall-through FIFO with occupancy count
module uart_rx_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign doPop  = pop && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign doPush = push && (!full || doPop);
    assign rdData = empty ? '0 : mem[rdPtr];
    always_ff @(posedge clock)
        if (doPush) mem[wrPtr] <= wrData;
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop) rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
endmodule

// File: rtl/uart_rx_fifo_gen.sv
// uart_rx_fifo_gen: oversampling UART receiver with majority vote and per-character status FIFO
// Define UART_RX_TIMEOUT_EN to build the idle character-timeout counter behind rxTimeout.
module uart_rx_fifo_gen
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          baudTick,
    input  logic                          uartRxLine,
    input  logic [6:0]                    controlReg,
    input  logic                          rxPop,
    input  logic                          clearOverrun,
    output logic [7:0]                    rxData,
    output logic [2:0]                    rxStatus,
    output logic                          rxEmpty,
    output logic                          rxFull,
    output logic [$clog2(FIFO_DEPTH):0]   rxCount,
    output logic                          overrunError,
    output logic                          rxTimeout
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    rxState_t state;
    logic syncA, syncB, prevLine;
    logic [TW-1:0] tickCnt;
    logic s0, s1, vote, sampleTick, wrap;
    logic [5:0] cfg;
    logic [7:0] dataReg;
    logic [2:0] bitIdx;
    logic lastStop, parBit, parErr, stopErr, brk, expPar, pushReq, popEff;
    logic [2:0] status;
    logic [10:0] headWord;
    assign wrap       = baudTick && tickCnt == LAST;
    assign sampleTick = baudTick && tickCnt == MID + TW'(1);
    assign vote       = (s0 & s1) | (s0 & syncB) | (s1 & syncB);
    assign expPar     = cfg[CTL_STICK] ? ~cfg[CTL_ODD] : ^dataReg ^ cfg[CTL_ODD];
    assign pushReq    = state == PUSH;
    assign popEff     = rxPop && !rxEmpty;
    assign status[ST_BREAK]  = brk;
    assign status[ST_PARITY] = parErr;
    assign status[ST_FRAME]  = stopErr | brk;
    always_ff @(posedge clock) begin
        if (reset) begin
            {syncA, syncB, prevLine} <= 3'b111;
            tickCnt <= '0;
            state <= IDLE;
            cfg <= '0;
            dataReg <= '0;
            bitIdx <= '0;
            {s0, s1, lastStop, parBit, parErr, stopErr, brk} <= '0;
        end else begin
            syncA <= uartRxLine;
            syncB <= syncA;
            prevLine <= syncB;
            if (baudTick) tickCnt <= wrap ? '0 : tickCnt + TW'(1);
            if (baudTick && tickCnt == MID - TW'(1)) s0 <= syncB;
            if (baudTick && tickCnt == MID) s1 <= syncB;
            case (state)
                IDLE: if (controlReg[CTL_ENABLE] && prevLine && !syncB) begin
                    cfg <= controlReg[5:0];
                    tickCnt <= '0;
                    dataReg <= '0;
                    bitIdx <= '0;
                    {lastStop, parBit, parErr, stopErr, brk} <= '0;
                    state <= START;
                end
                START: if (sampleTick) state <= vote ? IDLE : DATA;
                DATA: if (sampleTick) begin
                    dataReg[bitIdx] <= vote;
                    bitIdx <= bitIdx + 3'd1;
                    if ({1'b0, bitIdx} == dataBitCount(cfg[1:0]) - 4'd1)
                        state <= cfg[CTL_PAR_EN] ? PARITY : STOP;
                end
                PARITY: if (sampleTick) begin
                    parBit <= vote;
                    parErr <= vote != expPar;
                    state <= STOP;
                end
                // push on the last stop bit's mid-sample so a following start edge is not missed
                STOP: if (sampleTick) begin
                    stopErr <= stopErr | ~vote;
                    if (!lastStop) brk <= dataReg == 8'd0 && !parBit && !vote;
                    lastStop <= 1'b1;
                    if (lastStop || !cfg[CTL_STOP2]) state <= PUSH;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clock)
        if (reset) overrunError <= 1'b0;
        else if (pushReq && rxFull && !rxPop) overrunError <= 1'b1;
        else if (clearOverrun) overrunError <= 1'b0;
    uart_rx_sync_fifo #(.WIDTH(11), .DEPTH(FIFO_DEPTH)) fifo (
        .clock(clock),
        .reset(reset),
        .push(pushReq),
        .pop(rxPop),
        .wrData({status, dataReg}),
        .rdData(headWord),
        .empty(rxEmpty),
        .full(rxFull),
        .count(rxCount)
    );
    assign rxData   = headWord[7:0];
    assign rxStatus = headWord[10:8];
`ifdef UART_RX_TIMEOUT_EN
    localparam int BW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [BW-1:0] T_MAX = BW'(TIMEOUT_BITS);
    logic [BW-1:0] idleBits;
    always_ff @(posedge clock)
        if (reset || pushReq || popEff) idleBits <= '0;
        else if (!rxEmpty && state == IDLE && wrap && idleBits != T_MAX) idleBits <= idleBits + BW'(1);
    assign rxTimeout = idleBits == T_MAX;
`else
    assign rxTimeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// tb_uart_rx_fifo_gen: table, directed and randomized checks of the UART receiver FIFO
module tb_uart_rx_fifo_gen;
    localparam int OS = 16, DEPTH = 4, TP = 4;
    logic clock = 1'b0, reset = 1'b1, baudTick = 1'b0, uartRxLine = 1'b1;
    logic rxPop = 1'b0, clearOverrun = 1'b0;
    logic [6:0] controlReg = 7'h43;
    logic [7:0] rxData;
    logic [2:0] rxStatus, rxCount;
    logic rxEmpty, rxFull, overrunError, rxTimeout;
    int nCmp = 0, nBad = 0;
    typedef struct {
        logic [6:0] ctl;
        logic [7:0] data;
        logic pb, s1, s2;
        logic [7:0] expData;
        logic [2:0] expStatus;
    } vec_t;
    vec_t tbl[7];
    logic [10:0] mq[$];
    bit movr;
    always #5 clock = ~clock;
    uart_rx_fifo_gen #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(40)) dut (
        .clock(clock), .reset(reset), .baudTick(baudTick), .uartRxLine(uartRxLine),
        .controlReg(controlReg), .rxPop(rxPop), .clearOverrun(clearOverrun),
        .rxData(rxData), .rxStatus(rxStatus), .rxEmpty(rxEmpty), .rxFull(rxFull),
        .rxCount(rxCount), .overrunError(overrunError), .rxTimeout(rxTimeout)
    );
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // one bit-time of OS tick slots; optional mid-sample inversion and a pop aligned to the push cycle
    task automatic sendBit(input logic v, input bit glitch, input bit popAt);
        for (int s = 0; s < OS; s++) begin
            uartRxLine = (glitch && s == OS / 2) ? ~v : v;
            repeat (TP - 1) @(negedge clock);
            baudTick = 1'b1;
            @(negedge clock);
            baudTick = 1'b0;
            if (popAt && s == OS / 2 + 1) begin
                rxPop = 1'b1;
                @(negedge clock);
                rxPop = 1'b0;
            end
        end
    endtask
    task automatic sendFrame(input logic [6:0] ctl, input logic [6:0] ctlMid, input logic [7:0] d,
                             input logic pb, input logic s1, input logic s2, input bit glitch, input bit popAt);
        controlReg = ctl;
        repeat (2) sendBit(1'b1, 0, 0);
        sendBit(1'b0, 0, 0);
        controlReg = ctlMid;
        for (int i = 0; i < 5 + int'(ctl[1:0]); i++) sendBit(d[i], glitch, 0);
        if (ctl[2]) sendBit(pb, 0, 0);
        sendBit(s1, 0, popAt && !ctl[5]);
        if (ctl[5]) sendBit(s2, 0, popAt);
    endtask
    task automatic popCheck(input string name, input logic [7:0] d, input logic [2:0] st);
        cmp({name, " data"}, 32'(rxData), 32'(d));
        cmp({name, " status"}, 32'(rxStatus), 32'(st));
        rxPop = 1'b1;
        @(negedge clock);
        rxPop = 1'b0;
        @(negedge clock);
    endtask
    function automatic logic [10:0] model(input logic [6:0] ctl, input logic [7:0] d,
                                          input logic pb, input logic s1, input logic s2);
        int nb = 5 + int'(ctl[1:0]);
        logic [7:0] m = d & 8'((1 << nb) - 1);
        logic ep = ctl[4] ? ~ctl[3] : (($countones(m) % 2) == 1) ^ ctl[3];
        logic pe = ctl[2] && pb != ep;
        logic brk = m == 8'd0 && !(ctl[2] && pb) && !s1;
        logic fe = !s1 || (ctl[5] && !s2) || brk;
        return {brk, pe, fe, m};
    endfunction
    initial begin
        logic [6:0] ctl;
        logic [7:0] d;
        logic pb, s1, s2;
        logic [10:0] e;
        tbl[0] = '{7'h43, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3'b000};
        tbl[1] = '{7'h66, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 3'b010};
        tbl[2] = '{7'h66, 8'h41, 1'b1, 1'b1, 1'b0, 8'h41, 3'b011};
        tbl[3] = '{7'h4C, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h1F, 3'b000};
        tbl[4] = '{7'h5F, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 3'b010};
        tbl[5] = '{7'h57, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 3'b000};
        tbl[6] = '{7'h45, 8'h2D, 1'b0, 1'b0, 1'b1, 8'h2D, 3'b001};
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        cmp("reset empty", 32'(rxEmpty), 1);
        cmp("reset full", 32'(rxFull), 0);
        cmp("reset count", 32'(rxCount), 0);
        cmp("reset overrun", 32'(overrunError), 0);
        cmp("reset timeout", 32'(rxTimeout), 0);
        cmp("reset data", 32'(rxData), 0);
        cmp("reset status", 32'(rxStatus), 0);
        for (int i = 0; i < 7; i++) begin
            sendFrame(tbl[i].ctl, tbl[i].ctl, tbl[i].data, tbl[i].pb, tbl[i].s1, tbl[i].s2, 0, 0);
            cmp($sformatf("tbl%0d count", i), 32'(rxCount), 1);
            popCheck($sformatf("tbl%0d", i), tbl[i].expData, tbl[i].expStatus);
            cmp($sformatf("tbl%0d empty", i), 32'(rxEmpty), 1);
        end
        controlReg = 7'h43;
        repeat (2) sendBit(1'b1, 0, 0);
        uartRxLine = 1'b0;
        repeat (10) @(negedge clock);
        uartRxLine = 1'b1;
        sendBit(1'b1, 0, 0);
        cmp("short glitch empty", 32'(rxEmpty), 1);
        for (int s = 0; s < 3; s++) begin
            uartRxLine = 1'b0;
            repeat (TP - 1) @(negedge clock);
            baudTick = 1'b1;
            @(negedge clock);
            baudTick = 1'b0;
        end
        repeat (2) sendBit(1'b1, 0, 0);
        cmp("tick glitch empty", 32'(rxEmpty), 1);
        repeat (12) sendBit(1'b0, 0, 0);
        repeat (2) sendBit(1'b1, 0, 0);
        cmp("break count", 32'(rxCount), 1);
        popCheck("break", 8'h00, 3'b101);
        sendFrame(7'h43, 7'h43, 8'h3C, 1'b0, 1'b1, 1'b1, 1, 0);
        popCheck("vote glitch", 8'h3C, 3'b000);
        sendFrame(7'h03, 7'h03, 8'h5A, 1'b0, 1'b1, 1'b1, 0, 0);
        cmp("disabled count", 32'(rxCount), 0);
        sendFrame(7'h43, 7'h06, 8'hC3, 1'b1, 1'b1, 1'b1, 0, 0);
        cmp("mid disable count", 32'(rxCount), 1);
        popCheck("mid disable", 8'hC3, 3'b000);
        for (int k = 0; k < 5; k++) sendFrame(7'h43, 7'h43, 8'h11 + 8'(k), 1'b0, 1'b1, 1'b1, 0, 0);
        cmp("ovr full", 32'(rxFull), 1);
        cmp("ovr flag", 32'(overrunError), 1);
        cmp("ovr count", 32'(rxCount), 4);
        for (int k = 0; k < 4; k++) popCheck($sformatf("ovr pop%0d", k), 8'h11 + 8'(k), 3'b000);
        cmp("ovr drained", 32'(rxEmpty), 1);
        cmp("ovr sticky", 32'(overrunError), 1);
        clearOverrun = 1'b1;
        @(negedge clock);
        clearOverrun = 1'b0;
        cmp("ovr cleared", 32'(overrunError), 0);
        for (int k = 0; k < 4; k++) sendFrame(7'h43, 7'h43, 8'h21 + 8'(k), 1'b0, 1'b1, 1'b1, 0, 0);
        sendFrame(7'h43, 7'h43, 8'h25, 1'b0, 1'b1, 1'b1, 0, 1);
        cmp("pushpop overrun", 32'(overrunError), 0);
        cmp("pushpop count", 32'(rxCount), 4);
        cmp("pushpop full", 32'(rxFull), 1);
        for (int k = 0; k < 4; k++) popCheck($sformatf("pushpop pop%0d", k), 8'h22 + 8'(k), 3'b000);
        sendFrame(7'h43, 7'h43, 8'h99, 1'b0, 1'b1, 1'b1, 0, 0);
        repeat (2) sendBit(1'b1, 0, 0);
        sendBit(1'b0, 0, 0);
        sendBit(1'b1, 0, 0);
        uartRxLine = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        cmp("midreset count", 32'(rxCount), 0);
        cmp("midreset empty", 32'(rxEmpty), 1);
        sendFrame(7'h43, 7'h43, 8'h77, 1'b0, 1'b1, 1'b1, 0, 0);
        cmp("after reset count", 32'(rxCount), 1);
        popCheck("after reset", 8'h77, 3'b000);
        movr = 0;
        for (int n = 0; n < 30; n++) begin
            if (mq.size() > 0 && $urandom_range(2) != 0) begin
                popCheck("rnd head", mq[0][7:0], mq[0][10:8]);
                void'(mq.pop_front());
            end
            if ($urandom_range(3) == 0) begin
                clearOverrun = 1'b1;
                @(negedge clock);
                clearOverrun = 1'b0;
                movr = 0;
            end
            ctl = {1'b1, 6'($urandom)};
            d = 8'($urandom);
            pb = 1'($urandom);
            s1 = $urandom_range(7) != 0;
            s2 = $urandom_range(7) != 0;
            sendFrame(ctl, ctl, d, pb, s1, s2, 0, 0);
            e = model(ctl, d, pb, s1, s2);
            if (mq.size() == DEPTH) movr = 1;
            else mq.push_back(e);
            cmp("rnd count", 32'(rxCount), mq.size());
            cmp("rnd overrun", 32'(overrunError), 32'(movr));
            cmp("rnd empty", 32'(rxEmpty), 32'(mq.size() == 0));
            cmp("rnd full", 32'(rxFull), 32'(mq.size() == DEPTH));
        end
        while (mq.size() > 0) begin
            popCheck("rnd drain", mq[0][7:0], mq[0][10:8]);
            void'(mq.pop_front());
        end
        cmp("rnd drained", 32'(rxEmpty), 1);
        sendFrame(7'h43, 7'h43, 8'h6E, 1'b0, 1'b1, 1'b1, 0, 0);
        cmp("tmo count", 32'(rxCount), 1);
        repeat (600) begin
            uartRxLine = 1'b1;
            repeat (TP - 1) @(negedge clock);
            baudTick = 1'b1;
            @(negedge clock);
            baudTick = 1'b0;
        end
        cmp("tmo early", 32'(rxTimeout), 0);
        repeat (40) begin
            repeat (TP - 1) @(negedge clock);
            baudTick = 1'b1;
            @(negedge clock);
            baudTick = 1'b0;
        end
`ifdef UART_RX_TIMEOUT_EN
        cmp("tmo raised", 32'(rxTimeout), 1);
`else
        cmp("tmo tied low", 32'(rxTimeout), 0);
`endif
        rxPop = 1'b1;
        @(negedge clock);
        rxPop = 1'b0;
        cmp("tmo after pop", 32'(rxTimeout), 0);
        cmp("tmo empty", 32'(rxEmpty), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
